stdp_learner: RTL and testbench
===============================

# stdp_learner

Parametrised pair-based STDP learning block for N presynaptic channels and one postsynaptic neuron. Per-channel saturating spike timers feed a two-stage pipeline that applies windowed, scaled LTP/LTD to saturating unsigned weights. The block sits between the spike sources and the synapse weight consumers. It also offers a host write port for weight initialisation and a registered read port for readout.

## Interface
- NUM_PRE, 4: number of presynaptic channels (≥1)
- TIMER_W, 4: spike timer width; timers saturate at 2^TIMER_W-1
- WEIGHT_W, 8: unsigned weight width
- WINDOW, 8: STDP window in cycles, must satisfy WINDOW ≤ 2^TIMER_W-1
- LR_SHIFT, 0: learning-rate left shift applied to the raw delta
- W_INIT, 128: weight reset value
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- learn_en  in  1  enables weight updates; timers run regardless
- pre_spike  in  NUM_PRE  presynaptic spike per channel, sampled each edge
- post_spike  in  1  postsynaptic spike
- wr_en  in  1  host weight write strobe
- wr_idx  in  IDX_W  write channel, where IDX_W = max(1,$clog2(NUM_PRE))
- wr_data  in  WEIGHT_W  write value
- rd_idx  in  IDX_W  read channel
- rd_weight  out  WEIGHT_W  registered weight[rd_idx]
- weights  out  NUM_PRE*WEIGHT_W  all weights flattened; channel 0 in the LSBs
- update_valid  out  1  one-cycle pulse when stage 2 applied at least one delta
- update_mask  out  NUM_PRE  channels updated that cycle
- ltp_mask  out  NUM_PRE  subset of update_mask that were potentiations

## Operation
- **Timers**: pre timer i and the post timer each have a value T and a seen flag.
  - Spike sampled: T←0, seen←1.
  - No spike: T←min(T+1, 2^TIMER_W-1). Timers saturate and never wrap.
  - A registered value T means the last spike was T+1 cycles before the current edge.
- **Events** are evaluated on pre-update (registered) timer values.
  - **LTP on channel i**: post_spike=1, pre_spike[i]=0, pre seen[i]=1, pre T[i] < WINDOW → delta = +((WINDOW − T[i]) << LR_SHIFT).
  - **LTD on channel i**: pre_spike[i]=1, post_spike=0, post seen=1, post T < WINDOW → delta = −((WINDOW − T) << LR_SHIFT).
  - **Simultaneous** pre_spike[i] and post_spike: no update on channel i. Both timers still reset.
  - An unseen timer never pairs.
- **Stage 1**: registers per-channel delta magnitude, sign and valid. Valid is forced to 0 when learn_en=0.
- **Stage 2**: weight[i] ← clamp(weight[i] ± mag, 0, 2^WEIGHT_W-1).
  - Compute in WEIGHT_W+TIMER_W+LR_SHIFT+1 bits, then clamp; no wrap-around.
  - Back-to-back events on the same channel each apply in order, one per cycle.
- **Host write**: wr_en writes weight[wr_idx] at the next edge.
  - On a collision with a stage-2 apply to the same channel, the write wins and the delta is discarded; the channel is cleared in update_mask.
  - wr_idx ≥ NUM_PRE is ignored.
- **Readout**: rd_weight ← weight[rd_idx] each edge, reflecting weights before this edge's update. rd_idx ≥ NUM_PRE reads 0.

## Timing
- **Reset values**:
  - timers: T=0, seen=0
  - pipeline valids: 0
  - weights: W_INIT each
  - rd_weight: 0
  - update_valid, update_mask, ltp_mask: 0
- **Latency**: a spike sampled at edge e is visible on weights, update_valid and the masks after edge e+2. rd_weight shows it after edge e+3.
- **Throughput**: one event per channel per cycle; full pipeline, no stalls, no backpressure.
- **Reset mid-operation**: rst_n low at any edge flushes both stages; in-flight deltas are never applied.
- **learn_en**: sampled with the spikes at stage 1. Deasserting it does not cancel a delta already in stage 2.

## Structure
- **stdp_pkg** holds:
  - the IDX_W helper function
  - the delta-record typedef (mag, sign, valid)
  - the saturating-add function shared by the pipeline
- **stdp_spike_timer** (saturating counter with seen flag) is the natural sub-module: NUM_PRE+1 instances, TIMER_W parameter.

## Test plan
All scenarios use default parameters.
- **LTP**: pre_spike[0] at e0, post_spike at e3 (T=2) → weight0=134 after e5, update_valid pulse, ltp_mask=0001; other weights stay 128.
- **LTD**: post_spike at e0, pre_spike[1] at e5 (T=4) → weight1=124, update_mask=0010, ltp_mask=0000.
- **Simultaneous / unseen**: post_spike and pre_spike[2] together at e0 with no prior spikes, then again at e4 → no weight changes, update_valid never pulses.
- **Saturation**:
  - Write weight2=253; pre[2] at e0, post at e1 (delta +8) → 255.
  - Write weight3=3; post at e0, pre[3] at e1 (delta −8) → 0.
- **Window / timer limits**:
  - pre[0] then post 10 cycles later → no change.
  - Idle 40 cycles → timers hold 15; the following post yields no LTP.
  - learn_en=0 with a valid pair → no change.
- **Reset and collision**:
  - rst_n low for one edge the cycle after a qualifying post_spike → no apply, all weights 128, all outputs at reset values.
  - wr_en to channel 0 with 50 colliding with an LTP apply on channel 0 → weight0=50, update_mask bit 0 clear.

Source files
------------

// File: rtl/stdp_pkg.sv
`default_nettype none
//==============================================================================
// stdp_pkg -- shared types and helpers for the STDP learner (rev 1.0)
//==============================================================================
package stdp_pkg;

  localparam int MAG_MAX_W = 32;
  localparam int CALC_W    = 64;

  typedef logic [CALC_W-1:0] calc_t;

  typedef struct packed {
    logic [MAG_MAX_W-1:0] mag;
    logic                 sign;   // 1 = depression (subtract)
    logic                 valid;
  } delta_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Wide enough that w + mag can never wrap before the clamp.
  function automatic calc_t sat_apply(input calc_t w, input calc_t mag,
                                      input logic sub, input calc_t w_max);
    calc_t r;
    if (sub) begin
      r = (mag > w) ? '0 : (w - mag);
    end else begin
      r = w + mag;
      if (r > w_max) r = w_max;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stdp_spike_timer.sv
`default_nettype none
//==============================================================================
// stdp_spike_timer -- saturating cycles-since-spike counter with seen flag (rev 1.0)
//==============================================================================
module stdp_spike_timer #(
  parameter int TIMER_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_spike,
  output logic [TIMER_W-1:0] o_t,
  output logic               o_seen
);

  logic [TIMER_W-1:0] r_t;
  logic               r_seen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_t    <= '0;
      r_seen <= 1'b0;
    end else if (i_spike) begin
      r_t    <= '0;
      r_seen <= 1'b1;
    end else if (r_t != '1) begin
      r_t <= r_t + TIMER_W'(1);
    end
  end

  assign o_t    = r_t;
  assign o_seen = r_seen;

endmodule
`default_nettype wire

// File: rtl/stdp_learner.sv
`default_nettype none
//==============================================================================
// stdp_learner -- pair-based STDP with saturating weights and host port (rev 1.0)
//==============================================================================
module stdp_learner
  import stdp_pkg::*;
#(
  parameter  int NUM_PRE  = 4,
  parameter  int TIMER_W  = 4,
  parameter  int WEIGHT_W = 8,
  parameter  int WINDOW   = 8,
  parameter  int LR_SHIFT = 0,
  parameter  int W_INIT   = 128,
  localparam int IDX_W    = idx_w(NUM_PRE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         learn_en,
  input  logic [NUM_PRE-1:0]           pre_spike,
  input  logic                         post_spike,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [WEIGHT_W-1:0]          wr_data,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic [WEIGHT_W-1:0]          rd_weight,
  output logic [NUM_PRE*WEIGHT_W-1:0]  weights,
  output logic                         update_valid,
  output logic [NUM_PRE-1:0]           update_mask,
  output logic [NUM_PRE-1:0]           ltp_mask
);

  localparam logic [TIMER_W-1:0]  c_window  = TIMER_W'(WINDOW);
  localparam logic [WEIGHT_W-1:0] c_w_init  = WEIGHT_W'(W_INIT);
  localparam calc_t               c_w_max   = calc_t'({WEIGHT_W{1'b1}});
  localparam logic [IDX_W:0]      c_num_pre = (IDX_W+1)'(NUM_PRE);

  // Sampled spikes; the timers and the pairing logic both run off these, so
  // every timer value seen by the pairing logic is still the pre-spike value.
  logic [NUM_PRE-1:0]  r_pre;
  logic                r_post;
  logic                r_learn;

  logic [TIMER_W-1:0]  w_pre_t [NUM_PRE];
  logic [NUM_PRE-1:0]  w_pre_seen;
  logic [TIMER_W-1:0]  w_post_t;
  logic                w_post_seen;

  logic [NUM_PRE-1:0]  w_ltp;
  logic [NUM_PRE-1:0]  w_ltd;
  delta_t              w_s1_d [NUM_PRE];
  delta_t              r_s1   [NUM_PRE];

  logic [WEIGHT_W-1:0] r_weight [NUM_PRE];
  logic [WEIGHT_W-1:0] w_w_nxt  [NUM_PRE];
  logic [NUM_PRE-1:0]  w_upd;
  logic [NUM_PRE-1:0]  w_ltp_hit;
  logic                w_rd_ok;

  generate
    for (genvar g = 0; g < NUM_PRE; g++) begin : g_pre_timer
      stdp_spike_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_spike (r_pre[g]),
        .o_t     (w_pre_t[g]),
        .o_seen  (w_pre_seen[g])
      );
    end
  endgenerate

  stdp_spike_timer #(.TIMER_W(TIMER_W)) u_post_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_spike (r_post),
    .o_t     (w_post_t),
    .o_seen  (w_post_seen)
  );

  // Pairing: coincident pre/post on a channel cancels both directions.
  always_comb begin
    w_ltp = '0;
    w_ltd = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      w_ltp[i] = r_post && !r_pre[i] && w_pre_seen[i] && (w_pre_t[i] < c_window);
      w_ltd[i] = r_pre[i] && !r_post && w_post_seen && (w_post_t < c_window);
      w_s1_d[i]       = '0;
      w_s1_d[i].valid = r_learn && (w_ltp[i] || w_ltd[i]);
      w_s1_d[i].sign  = w_ltd[i];
      w_s1_d[i].mag   = w_ltd[i] ? (MAG_MAX_W'(c_window - w_post_t)   << LR_SHIFT)
                                 : (MAG_MAX_W'(c_window - w_pre_t[i]) << LR_SHIFT);
    end
  end

  // Host write takes priority over a same-cycle delta on that channel.
  always_comb begin
    w_upd     = '0;
    w_ltp_hit = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      w_w_nxt[i] = r_weight[i];
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        w_w_nxt[i] = wr_data;
      end else if (r_s1[i].valid) begin
        w_w_nxt[i]   = WEIGHT_W'(sat_apply(calc_t'(r_weight[i]), calc_t'(r_s1[i].mag),
                                           r_s1[i].sign, c_w_max));
        w_upd[i]     = 1'b1;
        w_ltp_hit[i] = !r_s1[i].sign;
      end
    end
  end

  assign w_rd_ok = ({1'b0, rd_idx} < c_num_pre);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre        <= '0;
      r_post       <= 1'b0;
      r_learn      <= 1'b0;
      for (int i = 0; i < NUM_PRE; i++) begin
        r_s1[i]     <= '0;
        r_weight[i] <= c_w_init;
      end
      rd_weight    <= '0;
      update_valid <= 1'b0;
      update_mask  <= '0;
      ltp_mask     <= '0;
    end else begin
      r_pre        <= pre_spike;
      r_post       <= post_spike;
      r_learn      <= learn_en;
      for (int i = 0; i < NUM_PRE; i++) begin
        r_s1[i]     <= w_s1_d[i];
        r_weight[i] <= w_w_nxt[i];
      end
      rd_weight    <= w_rd_ok ? r_weight[rd_idx] : '0;
      update_valid <= |w_upd;
      update_mask  <= w_upd;
      ltp_mask     <= w_ltp_hit;
    end
  end

  generate
    for (genvar g = 0; g < NUM_PRE; g++) begin : g_flat
      assign weights[g*WEIGHT_W +: WEIGHT_W] = r_weight[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_stdp_learner.sv
`default_nettype none
//==============================================================================
// tb_stdp_learner -- scoreboard bench for stdp_learner, default parameters (rev 1.0)
//==============================================================================
module tb_stdp_learner;

  localparam logic [31:0] W128 = 32'h8080_8080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        learn_en = 1'b1;
  logic [3:0]  pre_spike = '0;
  logic        post_spike = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_idx = '0;
  logic [7:0]  wr_data = '0;
  logic [1:0]  rd_idx = '0;
  logic [7:0]  rd_weight;
  logic [31:0] weights;
  logic        update_valid;
  logic [3:0]  update_mask;
  logic [3:0]  ltp_mask;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    string       tag;
    bit          is_rd;
    logic [31:0] w;
    logic [3:0]  um;
    logic [3:0]  lm;
    logic [7:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  stdp_learner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .learn_en     (learn_en),
    .pre_spike    (pre_spike),
    .post_spike   (post_spike),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .rd_idx       (rd_idx),
    .rd_weight    (rd_weight),
    .weights      (weights),
    .update_valid (update_valid),
    .update_mask  (update_mask),
    .ltp_mask     (ltp_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push_out(input int c, input string tag, input logic [31:0] w,
                          input logic [3:0] um, input logic [3:0] lm);
    exp_t x;
    x.cyc = c; x.tag = tag; x.is_rd = 1'b0; x.w = w; x.um = um; x.lm = lm; x.rd = '0;
    sb.push_back(x);
  endtask

  task automatic push_rd(input int c, input string tag, input logic [7:0] rd);
    exp_t x;
    x.cyc = c; x.tag = tag; x.is_rd = 1'b1; x.w = '0; x.um = '0; x.lm = '0; x.rd = rd;
    sb.push_back(x);
  endtask

  task automatic push_quiet(input int c0, input int c1, input string tag, input logic [31:0] w);
    for (int c = c0; c <= c1; c++) push_out(c, tag, w, 4'b0000, 4'b0000);
  endtask

  // Output sampling on the falling edge, after the edge numbered cyc.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc != cyc) begin
        check_eq({mon_e.tag, "_late"}, 32'(cyc), 32'(mon_e.cyc));
      end else if (mon_e.is_rd) begin
        check_eq({mon_e.tag, "_rd"}, 32'(rd_weight), 32'(mon_e.rd));
      end else begin
        check_eq({mon_e.tag, "_w"},  weights, mon_e.w);
        check_eq({mon_e.tag, "_uv"}, 32'(update_valid), 32'(|mon_e.um));
        check_eq({mon_e.tag, "_um"}, 32'(update_mask), 32'(mon_e.um));
        check_eq({mon_e.tag, "_lm"}, 32'(ltp_mask), 32'(mon_e.lm));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic spike(input logic [3:0] pre, input logic post);
    pre_spike  = pre;
    post_spike = post;
    step();
    pre_spike  = '0;
    post_spike = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int e0;

    // Reset state
    reset_dut();
    check_eq("rst_w",  weights, W128);
    check_eq("rst_rd", 32'(rd_weight), 32'd0);
    check_eq("rst_uv", 32'(update_valid), 32'd0);
    check_eq("rst_um", 32'(update_mask), 32'd0);
    check_eq("rst_lm", 32'(ltp_mask), 32'd0);

    // LTP: pre0 at e0, post at e3 (T=2) -> +6
    reset_dut();
    rd_idx = 2'd0;
    e0 = cyc + 1;
    push_quiet(e0, e0 + 4, "ltp_pre", W128);
    push_out(e0 + 5, "ltp", 32'h8080_8086, 4'b0001, 4'b0001);
    push_rd(e0 + 5, "ltp_rd_old", 8'd128);
    push_out(e0 + 6, "ltp_hold", 32'h8080_8086, 4'b0000, 4'b0000);
    push_rd(e0 + 6, "ltp_rd_new", 8'd134);
    spike(4'b0001, 1'b0);
    idle(2);
    spike(4'b0000, 1'b1);
    idle(5);

    // Back-to-back LTP: posts at e3 (+6) and e4 (+5)
    reset_dut();
    e0 = cyc + 1;
    push_quiet(e0, e0 + 4, "b2b_pre", W128);
    push_out(e0 + 5, "b2b_1", 32'h8080_8086, 4'b0001, 4'b0001);
    push_out(e0 + 6, "b2b_2", 32'h8080_808B, 4'b0001, 4'b0001);
    push_quiet(e0 + 7, e0 + 7, "b2b_hold", 32'h8080_808B);
    spike(4'b0001, 1'b0);
    idle(2);
    spike(4'b0000, 1'b1);
    spike(4'b0000, 1'b1);
    idle(4);

    // LTD: post at e0, pre1 at e5 (T=4) -> -4
    reset_dut();
    rd_idx = 2'd1;
    e0 = cyc + 1;
    push_quiet(e0, e0 + 6, "ltd_pre", W128);
    push_out(e0 + 7, "ltd", 32'h8080_7C80, 4'b0010, 4'b0000);
    push_quiet(e0 + 8, e0 + 8, "ltd_hold", 32'h8080_7C80);
    push_rd(e0 + 8, "ltd_rd", 8'd124);
    spike(4'b0000, 1'b1);
    idle(4);
    spike(4'b0010, 1'b0);
    idle(4);

    // Simultaneous / unseen: pre2+post at e0 and e4
    reset_dut();
    e0 = cyc + 1;
    push_quiet(e0, e0 + 7, "simul", W128);
    spike(4'b0100, 1'b1);
    idle(3);
    spike(4'b0100, 1'b1);
    idle(4);

    // Saturation high: weight2=253, +8 -> 255
    reset_dut();
    e0 = cyc + 1;
    push_quiet(e0, e0 + 3, "sat_hi_pre", 32'h80FD_8080);
    push_out(e0 + 4, "sat_hi", 32'h80FF_8080, 4'b0100, 4'b0100);
    push_quiet(e0 + 5, e0 + 5, "sat_hi_hold", 32'h80FF_8080);
    wr_en = 1'b1; wr_idx = 2'd2; wr_data = 8'd253;
    step();
    wr_en = 1'b0;
    spike(4'b0100, 1'b0);
    spike(4'b0000, 1'b1);
    idle(4);

    // Saturation low: weight3=3, -8 -> 0
    reset_dut();
    e0 = cyc + 1;
    push_quiet(e0, e0 + 3, "sat_lo_pre", 32'h0380_8080);
    push_out(e0 + 4, "sat_lo", 32'h0080_8080, 4'b1000, 4'b0000);
    push_quiet(e0 + 5, e0 + 5, "sat_lo_hold", 32'h0080_8080);
    wr_en = 1'b1; wr_idx = 2'd3; wr_data = 8'd3;
    step();
    wr_en = 1'b0;
    spike(4'b0000, 1'b1);
    spike(4'b1000, 1'b0);
    idle(4);

    // Window edge inside: post 8 cycles after pre (T=7) -> +1
    reset_dut();
    e0 = cyc + 1;
    push_quiet(e0, e0 + 9, "win_in_pre", W128);
    push_out(e0 + 10, "win_in", 32'h8080_8081, 4'b0001, 4'b0001);
    push_quiet(e0 + 11, e0 + 11, "win_in_hold", 32'h8080_8081);
    spike(4'b0001, 1'b0);
    idle(7);
    spike(4'b0000, 1'b1);
    idle(4);

    // Outside window: post 10 cycles after pre (T=9)
    reset_dut();
    e0 = cyc + 1;
    push_quiet(e0, e0 + 13, "win_out", W128);
    spike(4'b0001, 1'b0);
    idle(9);
    spike(4'b0000, 1'b1);
    idle(4);

    // Timer saturation: 40 idle cycles then post
    reset_dut();
    e0 = cyc + 1;
    push_quiet(e0, e0 + 44, "tsat", W128);
    spike(4'b0001, 1'b0);
    idle(40);
    spike(4'b0000, 1'b1);
    idle(4);

    // learn_en low during a qualifying pair
    reset_dut();
    learn_en = 1'b0;
    e0 = cyc + 1;
    push_quiet(e0, e0 + 7, "nolearn", W128);
    spike(4'b0001, 1'b0);
    idle(2);
    spike(4'b0000, 1'b1);
    idle(1);
    learn_en = 1'b1;
    idle(3);

    // Reset the cycle after a qualifying post
    reset_dut();
    rd_idx = 2'd0;
    e0 = cyc + 1;
    push_quiet(e0, e0 + 4, "midrst", W128);
    push_rd(e0 + 4, "midrst_rd0", 8'd0);
    push_quiet(e0 + 5, e0 + 7, "midrst_after", W128);
    push_rd(e0 + 7, "midrst_rd", 8'd128);
    spike(4'b0001, 1'b0);
    idle(2);
    spike(4'b0000, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(4);

    // Host write collides with the LTP apply on channel 0
    reset_dut();
    e0 = cyc + 1;
    push_quiet(e0, e0 + 4, "coll_pre", W128);
    push_out(e0 + 5, "coll", 32'h8080_8032, 4'b0000, 4'b0000);
    push_quiet(e0 + 6, e0 + 6, "coll_hold", 32'h8080_8032);
    spike(4'b0001, 1'b0);
    idle(2);
    spike(4'b0000, 1'b1);
    idle(1);
    wr_en = 1'b1; wr_idx = 2'd0; wr_data = 8'd50;
    step();
    wr_en = 1'b0;
    idle(3);

    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
